// File: rtl/time_digit_formatter_pkg.sv
// rtl/time_digit_formatter_pkg.sv - shared constants, state type and hour map for the time digit formatter
// Purpose: edit-field codes, separator default, digit-enable masks, FSM state type,
//          and the 24 h -> 12 h hour mapping used by the formatter top.
// Ports:   none (package).
package time_digit_formatter_pkg;

   // edit_field encodings
   localparam logic [1:0] FLD_NONE = 2'd0;
   localparam logic [1:0] FLD_HOUR = 2'd1;
   localparam logic [1:0] FLD_MIN  = 2'd2;
   localparam logic [1:0] FLD_SEC  = 2'd3;

   localparam logic [3:0] SEP_CODE_DEF = 4'hA;

   // digit-enable masks, bit i pairs with digit di
   localparam logic [7:0] EN_ALL    = 8'hFF;
   localparam logic [7:0] EN_BLANK  = 8'h00;
   localparam logic [7:0] MASK_HOUR = 8'hC0;
   localparam logic [7:0] MASK_MIN  = 8'h18;
   localparam logic [7:0] MASK_SEC  = 8'h03;
   localparam logic [7:0] MASK_SEP  = 8'h24;
   localparam logic [7:0] MASK_LEAD = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_COMMIT
   } fmt_state_t;

   // 0 -> 12, 1..12 unchanged, 13..31 -> h-12 (out-of-range hours pass through the same rule)
   function automatic logic [4:0] map_12h(input logic [4:0] h);
      if (h == 5'd0)
         return 5'd12;
      else if (h > 5'd12)
         return h - 5'd12;
      else
         return h;
   endfunction

endpackage

// File: rtl/time_digit_formatter_bin6_to_bcd2.sv
// rtl/time_digit_formatter_bin6_to_bcd2.sv - sequential 6-bit binary to 2-digit BCD (double-dabble)
// Purpose: load captures a 6-bit value and clears the BCD register; each step applies the
//          add-3 correction to both nibbles and shifts one binary bit in. Six steps give
//          the result (0..63 -> tens 0..6, ones 0..9).
// Ports:   clk, rst_n (async, active low), load, step, bin[5:0] in; bcd[7:0] out {tens, ones}.
module bin6_to_bcd2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       step,
   input  logic [5:0] bin,
   output logic [7:0] bcd
);

   logic [5:0] shift_q;
   logic [7:0] bcd_q;
   logic [7:0] adj;

   // add-3 to any nibble >= 5 so the following shift carries correctly into the next decade
   always_comb begin
      adj = bcd_q;
      if (bcd_q[3:0] >= 4'd5) adj[3:0] = bcd_q[3:0] + 4'd3;
      if (bcd_q[7:4] >= 4'd5) adj[7:4] = bcd_q[7:4] + 4'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bcd_q   <= '0;
      end else if (load) begin
         shift_q <= bin;
         bcd_q   <= '0;
      end else if (step) begin
         // tens never exceeds 6, so adj[7] is always 0 and dropping it loses nothing
         bcd_q   <= {adj[6:0], shift_q[5]};
         shift_q <= {shift_q[4:0], 1'b0};
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/time_digit_formatter.sv
// rtl/time_digit_formatter.sv - hour/minute/second to 8 seven-segment digit codes with enables
// Purpose: snapshots h/m/s/mode on change, converts via three double-dabble units, and commits
//          all digits and pm in a single edge. Drives a registered per-digit enable with
//          separator, leading-zero and edit-field blink handling.
// Ports:   clk, rst_n (async, active low); hour[4:0], minute[5:0], second[5:0], mode_12h,
//          edit_field[1:0] in; d7..d0[3:0] (d7 leftmost), en[7:0], pm, busy out.
module time_digit_formatter
   import time_digit_formatter_pkg::*;
#(
   parameter int unsigned BLINK_DIV = 25_000_000,
   parameter logic [3:0]  SEP_CODE  = SEP_CODE_DEF,
   parameter bit          SEP_EN    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] hour,
   input  logic [5:0] minute,
   input  logic [5:0] second,
   input  logic       mode_12h,
   input  logic [1:0] edit_field,
   output logic [3:0] d7,
   output logic [3:0] d6,
   output logic [3:0] d5,
   output logic [3:0] d4,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic [7:0] en,
   output logic       pm,
   output logic       busy
);

   localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

   fmt_state_t state_q, state_d;

   logic [4:0] hour_q;
   logic [5:0] min_q;
   logic [5:0] sec_q;
   logic       mode_q;
   logic       pm_snap_q;
   logic       force_q;      // guarantees one conversion after reset regardless of inputs
   logic [2:0] step_cnt_q;
   logic       valid_q;      // at least one COMMIT has happened since reset
   logic       lead_blank_q;

   logic [CW-1:0] blink_cnt_q;
   logic          blink_phase_q;

   logic       changed;
   logic       do_load;
   logic       do_step;
   logic       do_commit;
   logic [4:0] hour_mapped;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       lead_blank_new;
   logic       valid_next;
   logic       lead_next;
   logic [7:0] blink_mask;
   logic [7:0] en_d;

   assign changed     = {hour, minute, second, mode_12h} != {hour_q, min_q, sec_q, mode_q};
   assign do_load     = (state_q == ST_LOAD);
   assign do_step     = (state_q == ST_SHIFT);
   assign do_commit   = (state_q == ST_COMMIT);
   assign hour_mapped = mode_12h ? map_12h(hour) : hour;
   assign busy        = (state_q != ST_IDLE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (force_q || changed) state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_SHIFT;
         ST_SHIFT:  if (step_cnt_q == 3'd5) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- snapshot and step counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hour_q     <= '0;
         min_q      <= '0;
         sec_q      <= '0;
         mode_q     <= 1'b0;
         pm_snap_q  <= 1'b0;
         force_q    <= 1'b1;
         step_cnt_q <= '0;
      end else if (do_load) begin
         hour_q     <= hour;
         min_q      <= minute;
         sec_q      <= second;
         mode_q     <= mode_12h;
         pm_snap_q  <= mode_12h && (hour >= 5'd12);
         force_q    <= 1'b0;
         step_cnt_q <= '0;
      end else if (do_step) begin
         step_cnt_q <= step_cnt_q + 3'd1;
      end
   end

   // ---------------- converters ----------------
   // Load samples the live inputs on the same edge the snapshot registers do, so both agree.
   bin6_to_bcd2 u_hour_cvt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (do_load),
      .step  (do_step),
      .bin   ({1'b0, hour_mapped}),
      .bcd   (hour_bcd)
   );

   bin6_to_bcd2 u_min_cvt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (do_load),
      .step  (do_step),
      .bin   (minute),
      .bcd   (min_bcd)
   );

   bin6_to_bcd2 u_sec_cvt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (do_load),
      .step  (do_step),
      .bin   (second),
      .bcd   (sec_bcd)
   );

   // ---------------- commit ----------------
   assign lead_blank_new = mode_q && (hour_bcd[7:4] == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d7 <= '0; d6 <= '0; d5 <= '0; d4 <= '0;
         d3 <= '0; d2 <= '0; d1 <= '0; d0 <= '0;
         pm           <= 1'b0;
         valid_q      <= 1'b0;
         lead_blank_q <= 1'b0;
      end else if (do_commit) begin
         d7 <= hour_bcd[7:4];
         d6 <= hour_bcd[3:0];
         d5 <= SEP_CODE;
         d4 <= min_bcd[7:4];
         d3 <= min_bcd[3:0];
         d2 <= SEP_CODE;
         d1 <= sec_bcd[7:4];
         d0 <= sec_bcd[3:0];
         pm           <= pm_snap_q;
         valid_q      <= 1'b1;
         lead_blank_q <= lead_blank_new;
      end
   end

   // ---------------- blink timebase ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == CNT_MAX) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
   end

   // ---------------- enable register ----------------
   // The commit-cycle values are folded in so en switches on the same edge as the digits.
   assign valid_next = valid_q | do_commit;
   assign lead_next  = do_commit ? lead_blank_new : lead_blank_q;

   always_comb begin
      blink_mask = EN_BLANK;
      unique case (edit_field)
         FLD_NONE: blink_mask = EN_BLANK;
         FLD_HOUR: blink_mask = MASK_HOUR;
         FLD_MIN:  blink_mask = MASK_MIN;
         FLD_SEC:  blink_mask = MASK_SEC;
         default:  blink_mask = EN_BLANK;
      endcase
   end

   always_comb begin
      en_d = EN_ALL;
      if (!SEP_EN)       en_d = en_d & ~MASK_SEP;
      if (lead_next)     en_d = en_d & ~MASK_LEAD;
      if (blink_phase_q) en_d = en_d & ~blink_mask;
      if (!valid_next)   en_d = EN_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en <= EN_BLANK;
      else        en <= en_d;
   end

endmodule
